wb4_sync_fifo_lvl: RTL and testbench

WB4_SYNC_FIFO_LVL -- requirements
Module: wb4_sync_fifo_lvl

---
 rtl/wb4_fifo_pkg.sv | 16 +
 rtl/generic_sbram.sv | 29 ++
 rtl/wb4_sync_fifo_lvl.sv | 120 ++++++++++++
 tb/tb_wb4_sync_fifo_lvl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb4_fifo_pkg.sv
// Shared definitions for the Wishbone-style synchronous FIFO: status bit
// positions inside the registered status vector and the level-width helper.
package wb4_fifo_pkg;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_AFULL  = 2;
  localparam int STAT_AEMPTY = 3;
  localparam int STAT_W      = 4;

  // One extra bit so the level can represent a completely full FIFO.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/generic_sbram.sv
// Simple dual-port block RAM: one write port, one registered read port with
// read enable; the output register holds its value between reads.
module generic_sbram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is the only part with a reset; the array is left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wb4_sync_fifo_lvl.sv
// Synchronous FIFO with pipelined Wishbone-style write and read slaves.
// Full/empty and watermarks are registered from the next-state level count.
module wb4_sync_fifo_lvl
  import wb4_fifo_pkg::*;
#(
  parameter int P_DATA_MSB = 7,
  parameter int P_DEPTH    = 128,
  parameter int P_AFULL    = P_DEPTH - 4,
  parameter int P_AEMPTY   = 4,
  parameter int P_USE_BRAM = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic                      i_wb4_in_scyc,
  input  logic                      i_wb4_in_sstb,
  input  logic [P_DATA_MSB:0]       i_wb4_in_sdata,
  output logic                      o_wb4_in_sack,
  output logic                      o_wb4_in_sstall,
  input  logic                      i_wb4_out_scyc,
  input  logic                      i_wb4_out_sstb,
  output logic                      o_wb4_out_sack,
  output logic [P_DATA_MSB:0]       o_wb4_out_sdata,
  output logic                      o_wb4_out_sstall,
  output logic [$clog2(P_DEPTH):0]  o_level,
  output logic                      o_almost_full,
  output logic                      o_almost_empty
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int LW = lvl_w(P_DEPTH);
  localparam logic [STAT_W-1:0] STAT_RST = STAT_W'((1 << STAT_EMPTY) | (1 << STAT_AEMPTY));

  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level, level_nxt;
  logic [STAT_W-1:0]   status, status_nxt;
  logic                wr_acc, rd_acc;
  logic                in_ack_p1, out_ack_p1;
  logic [P_DATA_MSB:0] rd_data_p1;

  assign wr_acc = i_wb4_in_scyc & i_wb4_in_sstb & ~status[STAT_FULL] & ~i_clear;
  assign rd_acc = i_wb4_out_scyc & i_wb4_out_sstb & ~status[STAT_EMPTY] & ~i_clear;

  always_comb begin
    level_nxt = level;
    if (i_clear)                level_nxt = '0;
    else if (wr_acc && !rd_acc) level_nxt = level + LW'(1);
    else if (rd_acc && !wr_acc) level_nxt = level - LW'(1);

    status_nxt              = '0;
    status_nxt[STAT_FULL]   = (level_nxt == LW'(P_DEPTH));
    status_nxt[STAT_EMPTY]  = (level_nxt == '0);
    status_nxt[STAT_AFULL]  = (level_nxt >= LW'(P_AFULL));
    status_nxt[STAT_AEMPTY] = (level_nxt <= LW'(P_AEMPTY));
  end

  // Stage p0 -> p1: pointers, level, status and acks register together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      status     <= STAT_RST;
      in_ack_p1  <= 1'b0;
      out_ack_p1 <= 1'b0;
    end else begin
      level      <= level_nxt;
      status     <= status_nxt;
      in_ack_p1  <= wr_acc;
      out_ack_p1 <= rd_acc;
      if (i_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Both storage styles share the same one-cycle registered read timing.
  generate
    if (P_USE_BRAM == 1) begin : g_bram
      generic_sbram #(
        .DATA_W(P_DATA_MSB + 1),
        .ADDR_W(AW)
      ) u_ram (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(i_wb4_in_sdata),
        .re   (rd_acc),
        .raddr(rd_ptr),
        .rdata(rd_data_p1)
      );
    end else begin : g_lut
      logic [P_DATA_MSB:0] mem [P_DEPTH];

      always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_ptr] <= i_wb4_in_sdata;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    rd_data_p1 <= '0;
        else if (rd_acc) rd_data_p1 <= mem[rd_ptr];
      end
    end
  endgenerate

  assign o_wb4_in_sack    = in_ack_p1;
  assign o_wb4_out_sack   = out_ack_p1;
  assign o_wb4_out_sdata  = rd_data_p1;
  assign o_wb4_in_sstall  = status[STAT_FULL];
  assign o_wb4_out_sstall = status[STAT_EMPTY];
  assign o_almost_full    = status[STAT_AFULL];
  assign o_almost_empty   = status[STAT_AEMPTY];
  assign o_level          = level;

endmodule

// File: tb/tb_wb4_sync_fifo_lvl.sv
// Directed bench for wb4_sync_fifo_lvl at depth 8: reset, fill, drain,
// empty/full boundaries, sustained concurrent traffic, clear and mid-burst reset.
module tb_wb4_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst_n, clear;
  logic       wcyc, wstb, rcyc, rstb;
  logic [7:0] wdata, rdata;
  logic       in_ack, in_stall, out_ack, out_stall, afull, aempty;
  logic [3:0] level;
  int         checks = 0;
  int         errors = 0;
  int         exp_lv;

  always #5 clk = ~clk;

  wb4_sync_fifo_lvl #(
    .P_DATA_MSB(7),
    .P_DEPTH   (8),
    .P_AFULL   (6),
    .P_AEMPTY  (2),
    .P_USE_BRAM(1)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_clear         (clear),
    .i_wb4_in_scyc   (wcyc),
    .i_wb4_in_sstb   (wstb),
    .i_wb4_in_sdata  (wdata),
    .o_wb4_in_sack   (in_ack),
    .o_wb4_in_sstall (in_stall),
    .i_wb4_out_scyc  (rcyc),
    .i_wb4_out_sstb  (rstb),
    .o_wb4_out_sack  (out_ack),
    .o_wb4_out_sdata (rdata),
    .o_wb4_out_sstall(out_stall),
    .o_level         (level),
    .o_almost_full   (afull),
    .o_almost_empty  (aempty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    wcyc  = w;
    wstb  = w;
    wdata = d;
    rcyc  = r;
    rstb  = r;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ack"},    32'(in_ack),    0);
    chk({tag, "_out_ack"},   32'(out_ack),   0);
    chk({tag, "_in_stall"},  32'(in_stall),  0);
    chk({tag, "_out_stall"}, 32'(out_stall), 1);
    chk({tag, "_afull"},     32'(afull),     0);
    chk({tag, "_aempty"},    32'(aempty),    1);
    chk({tag, "_rdata"},     32'(rdata),     0);
    chk({tag, "_level"},     32'(level),     0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) step();
    chk_reset_state("rst0");
    rst_n = 1'b1;
    step();
    chk("rst0_level_after", 32'(level), 0);

    // Fill: 0x01..0x09 back to back, the ninth is refused.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
      exp_lv = (i > 8) ? 8 : i;
      chk($sformatf("fill%0d_ack", i),   32'(in_ack),   (i <= 8) ? 1 : 0);
      chk($sformatf("fill%0d_level", i), 32'(level),    exp_lv);
      chk($sformatf("fill%0d_afull", i), 32'(afull),    (exp_lv >= 6) ? 1 : 0);
      chk($sformatf("fill%0d_stall", i), 32'(in_stall), (i >= 8) ? 1 : 0);
      if (i == 1) chk("fill1_out_stall", 32'(out_stall), 0);
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk("fill_ack_one_cycle", 32'(in_ack), 0);

    // Drain: nine reads from full, data in order, last read refused.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      exp_lv = (i > 8) ? 0 : 8 - i;
      chk($sformatf("drain%0d_ack", i),    32'(out_ack),   (i <= 8) ? 1 : 0);
      chk($sformatf("drain%0d_data", i),   32'(rdata),     (i <= 8) ? i : 8);
      chk($sformatf("drain%0d_level", i),  32'(level),     exp_lv);
      chk($sformatf("drain%0d_aempty", i), 32'(aempty),    (exp_lv <= 2) ? 1 : 0);
      chk($sformatf("drain%0d_stall", i),  32'(out_stall), (i >= 8) ? 1 : 0);
      if (i == 1) chk("drain1_in_stall", 32'(in_stall), 0);
    end

    // Empty with both strobes: only the write goes in.
    drive(1'b1, 8'h33, 1'b1);
    step();
    chk("empty_both_in_ack",  32'(in_ack),  1);
    chk("empty_both_out_ack", 32'(out_ack), 0);
    chk("empty_both_level",   32'(level),   1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("empty_rd_ack",   32'(out_ack), 1);
    chk("empty_rd_data",  32'(rdata),   32'h33);
    chk("empty_rd_level", 32'(level),   0);

    // Concurrent: prime to level 4, then 20 cycles of write+read.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      step();
    end
    chk("conc_prime_level", 32'(level), 4);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'(8'h14 + k), 1'b1);
      step();
      chk($sformatf("conc%0d_in_ack", k),  32'(in_ack),  1);
      chk($sformatf("conc%0d_out_ack", k), 32'(out_ack), 1);
      chk($sformatf("conc%0d_data", k),    32'(rdata),   32'h10 + k);
      chk($sformatf("conc%0d_level", k),   32'(level),   4);
    end

    // Top up to full (contents 0x24..0x2B), then both strobes at full.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h28 + i), 1'b0);
      step();
    end
    chk("full_level", 32'(level),    8);
    chk("full_stall", 32'(in_stall), 1);
    drive(1'b1, 8'hEE, 1'b1);
    step();
    chk("full_both_in_ack",  32'(in_ack),   0);
    chk("full_both_out_ack", 32'(out_ack),  1);
    chk("full_both_data",    32'(rdata),    32'h24);
    chk("full_both_level",   32'(level),    7);
    chk("full_both_stall",   32'(in_stall), 0);

    // Down to level 5, then clear with both strobes active.
    drive(1'b0, 8'h00, 1'b1);
    repeat (2) step();
    chk("pre_clear_level", 32'(level), 5);
    chk("pre_clear_data",  32'(rdata), 32'h26);
    drive(1'b1, 8'h77, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("clr_in_ack",    32'(in_ack),    0);
    chk("clr_out_ack",   32'(out_ack),   0);
    chk("clr_level",     32'(level),     0);
    chk("clr_out_stall", 32'(out_stall), 1);
    chk("clr_in_stall",  32'(in_stall),  0);
    chk("clr_afull",     32'(afull),     0);
    chk("clr_aempty",    32'(aempty),    1);
    chk("clr_data_held", 32'(rdata),     32'h26);
    drive(1'b1, 8'hA5, 1'b0);
    step();
    chk("clr_wr_ack",   32'(in_ack), 1);
    chk("clr_wr_level", 32'(level),  1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("clr_rd_ack",  32'(out_ack), 1);
    chk("clr_rd_data", 32'(rdata),   32'hA5);

    // Mid-burst reset at level 5: outputs must change without a clock edge.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b0);
      step();
    end
    chk("rst1_pre_level", 32'(level),  5);
    chk("rst1_pre_ack",   32'(in_ack), 1);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk_reset_state("rst1");
    step();
    rst_n = 1'b1;
    step();
    chk("rst1_level_after", 32'(level),     0);
    chk("rst1_empty_after", 32'(out_stall), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
